// File: rtl/lab71_soc_irq_ctrl.sv
// Interrupt aggregator: synchronises, latches, masks and priority-encodes up to 16 irq lines behind an Avalon-MM slave.
// Latency: level source raises irq 3 edges after capture, edge source 4; reads return 1 cycle after address.
// Backpressure: none; the slave has no waitrequest and accepts every access in one cycle.
module lab71_soc_irq_ctrl #(
    parameter int          NUM_IRQ      = 8,
    parameter logic [15:0] RESET_ENABLE = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq,
    output logic [4:0]         irq_vector
);

    logic [NUM_IRQ-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d, edge_q, edge_d;
    logic [NUM_IRQ-1:0] edge_latch_q, edge_latch_d, soft_latch_q, soft_latch_d;
    logic [15:0]        readdata_q, readdata_d;
    logic               irq_q, irq_d;
    logic [4:0]         irq_vector_q, irq_vector_d;

    logic               wr_vld;
    logic [NUM_IRQ-1:0] wr_dat, rise, pending, active;
    logic [15:0]        raw_w, pend_w, en_w, edge_w;
    logic [3:0]         vec_idx;
    logic               unused_wdat;

    assign wr_vld      = chipselect & ~write_n;
    assign wr_dat      = writedata[NUM_IRQ-1:0];
    assign unused_wdat = ^writedata;
    assign rise        = s2_q & ~s3_q;
    assign pending     = (s2_q & ~edge_q) | edge_latch_q | soft_latch_q;
    assign active      = pending & enable_q;

    always_comb begin
        s1_d = irq_in;
        s2_d = s1_q;
        s3_d = s2_q;

        enable_d = enable_q;
        edge_d   = edge_q;
        if (wr_vld && address == 3'd2) enable_d = wr_dat;
        if (wr_vld && address == 3'd3) edge_d   = wr_dat;

        // Clear first, then set, so a coincident edge survives the W1C.
        edge_latch_d = edge_latch_q;
        soft_latch_d = soft_latch_q;
        if (wr_vld && address == 3'd1) begin
            edge_latch_d = edge_latch_d & ~wr_dat;
            soft_latch_d = soft_latch_d & ~wr_dat;
        end
        edge_latch_d = edge_latch_d | (rise & edge_q);
        if (wr_vld && address == 3'd5) soft_latch_d = soft_latch_d | wr_dat;

        vec_idx = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) vec_idx = i[3:0];
        end
        irq_d        = |active;
        irq_vector_d = {|active, vec_idx};

        raw_w  = '0;
        pend_w = '0;
        en_w   = '0;
        edge_w = '0;
        raw_w[NUM_IRQ-1:0]  = s2_q;
        pend_w[NUM_IRQ-1:0] = pending;
        en_w[NUM_IRQ-1:0]   = enable_q;
        edge_w[NUM_IRQ-1:0] = edge_q;

        case (address)
            3'd0:    readdata_d = raw_w;
            3'd1:    readdata_d = pend_w;
            3'd2:    readdata_d = en_w;
            3'd3:    readdata_d = edge_w;
            3'd4:    readdata_d = {11'b0, irq_vector_q};
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q         <= '0;
            s2_q         <= '0;
            s3_q         <= '0;
            enable_q     <= RESET_ENABLE[NUM_IRQ-1:0];
            edge_q       <= '0;
            edge_latch_q <= '0;
            soft_latch_q <= '0;
            readdata_q   <= '0;
            irq_q        <= 1'b0;
            irq_vector_q <= '0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            enable_q     <= enable_d;
            edge_q       <= edge_d;
            edge_latch_q <= edge_latch_d;
            soft_latch_q <= soft_latch_d;
            readdata_q   <= readdata_d;
            irq_q        <= irq_d;
            irq_vector_q <= irq_vector_d;
        end
    end

    assign readdata   = readdata_q;
    assign irq        = irq_q;
    assign irq_vector = irq_vector_q;

endmodule
